wb_arbiter2: RTL
================

// Module: wb_arbiter2
// PURPOSE
//  Two-master, one-slave Wishbone classic arbiter that shares the single-port wb_ram
//  between the core's instruction-fetch bus (m0) and data bus (m1) inside naive_soc.
//  Grants round-robin, holds the grant for the whole cycle (cyc), and muxes requests and
//  responses. A bus watchdog returns err to the master if the slave never acks.
// PARAMETERS
//  AW       32   address width
//  DW       32   data width; SW = DW/8 byte selects
//  TIMEOUT  255  max wait cycles for ack per strobe; 0 disables watchdog (err never set)
// PORTS
//  clk          in   1    system clock
//  reset        in   1    synchronous, active-high reset
//  m0_addr      in   AW   master 0 (ibus) address
//  m0_wdata     in   DW   master 0 write data
//  m0_sel       in   SW   master 0 byte selects
//  m0_we        in   1    master 0 write enable
//  m0_cyc       in   1    master 0 cycle / bus request
//  m0_stb       in   1    master 0 strobe
//  m0_rdata     out  DW   master 0 read data
//  m0_ack       out  1    master 0 acknowledge
//  m0_err       out  1    master 0 watchdog error
//  m1_*         --   --   identical set for master 1 (dbus)
//  s_addr,s_wdata,s_sel,s_we,s_cyc,s_stb  out  AW,DW,SW,1,1,1  to slave (wb_ram)
//  s_rdata      in   DW   slave read data
//  s_ack        in   1    slave acknowledge
// BEHAVIOUR
//  - FSM states: IDLE, G0, G1, ERR; plus 1-bit last_grant, watchdog counter wd_cnt.
//  - Reset: state=IDLE, last_grant=1 (m0 wins first tie), wd_cnt=0, mX_err=0.
//    All s_* outputs and mX_ack are 0, driven from the FSM state.
//  - IDLE: m0_cyc only -> G0; m1_cyc only -> G1.
//    Both -> grant the master != last_grant. Neither -> IDLE.
//  - Grant is registered: slave sees s_cyc/s_stb one cycle after the master raises cyc.
//  - In Gn: s_* = mn_* combinationally, with s_cyc = mn_cyc and s_stb = mn_stb.
//    mn_ack = s_ack, mn_rdata = s_rdata. Other master: ack=0, err=0, rdata=0.
//  - Gn held while mn_cyc=1 (bus lock across back-to-back strobes; no preemption).
//  - mn_cyc=0 in Gn: s_cyc/s_stb drop the same cycle. Next state IDLE, last_grant=n.
//    A late s_ack is routed to nobody.
//  - wb_ram acks in alternating cycles (ack blocks the next strobe).
//    The arbiter passes this through unchanged; no extra latency beyond the grant cycle.
//  - Watchdog: wd_cnt increments each cycle with s_cyc&s_stb&~s_ack. It clears on s_ack,
//    on grant change, or when stb=0.
//    On wd_cnt==TIMEOUT-1 with no ack: mn_err=1 for exactly that cycle, s_cyc/s_stb
//    forced 0 next cycle, state -> ERR (one cycle, all s_* 0), then IDLE.
//  - s_ack and timeout in the same cycle: ack wins, no err.
//  - Re-request after ERR follows normal IDLE arbitration (last_grant = erroring master).
//  - Reset mid-transfer: next edge returns to IDLE. The slave's pending ack is ignored.
//  - wd_cnt width = $clog2(TIMEOUT+1); saturates, never wraps.
// STRUCTURE
//  - Shared header wb_defs.vh: Wishbone state encodings (ARB_IDLE/G0/G1/ERR),
//    default AW/DW, TIMEOUT default.
//  - One sub-module, wb_arb_watchdog: counter + err pulse, parameterised by TIMEOUT,
//    inputs clr/tick, output expire.
//  - Datapath muxes stay inline in wb_arbiter2.
// TESTING (bench: wb_arbiter2 + wb_ram, two BFM masters)
//  1. m0 read @0x10 alone: s_cyc at cycle 1, m0_ack at cycle 2, m0_rdata=mem word.
//     m1_ack stays 0.
//  2. m0 and m1 cyc raised same cycle after reset: G0 first. After m0 drops cyc, G1
//     serves m1. Next tie goes to m0 again.
//  3. m1 holds cyc for 4 write strobes (0xA5A5A5A5, sel=4'b0011):
//     m0 blocked until release; RAM bytes 0,1 written, bytes 2,3 unchanged.
//  4. m0 drops cyc one cycle after stb, before ack: s_cyc=0 same cycle, stray ack not
//     seen by m0 or m1.
//  5. TIMEOUT=4, slave ack tied 0: m0_err pulses one cycle 4 cycles after s_stb.
//     One ERR cycle follows with all s_*=0, then IDLE.
//  6. reset asserted during G1 write: next cycle all s_*=0, state IDLE, no ack/err output.

Source files
------------

// File: rtl/wb_arbiter2_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM state encoding,
// default bus geometry and the watchdog counter sizing helper.
package wb_arbiter2_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_G0   = 2'd1,
        ARB_G1   = 2'd2,
        ARB_ERR  = 2'd3
    } arb_state_e;

    localparam int WB_AW_DEF      = 32;
    localparam int WB_DW_DEF      = 32;
    localparam int WB_TIMEOUT_DEF = 255;

    // A disabled watchdog (timeout 0) still needs a one-bit counter to stay legal.
    function automatic int wd_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/wb_arbiter2_watchdog.sv
// Bus watchdog: counts cycles a strobe waits for ack and flags expiry on the
// last allowed wait cycle. The counter saturates instead of wrapping.
module wb_arb_watchdog
    import wb_arbiter2_pkg::*;
#(
    parameter int TIMEOUT = WB_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic tick,
    output logic expire
);

    localparam int CW     = wd_width(TIMEOUT);
    localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] LAST = CW'(LAST_I);
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

    logic [CW-1:0] wd_cnt_q;
    logic [CW-1:0] wd_cnt_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (clr) begin
            wd_cnt_d = '0;
        end else if (tick && (wd_cnt_q != SAT)) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign expire = (TIMEOUT != 0) && tick && (wd_cnt_q == LAST);

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin grant, bus lock
// for the whole cycle, and a watchdog that errors a master whose slave never acks.
module wb_arbiter2
    import wb_arbiter2_pkg::*;
#(
    parameter int AW      = WB_AW_DEF,
    parameter int DW      = WB_DW_DEF,
    parameter int TIMEOUT = WB_TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_sel,
    input  logic            m0_we,
    input  logic            m0_cyc,
    input  logic            m0_stb,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_ack,
    output logic            m0_err,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_sel,
    input  logic            m1_we,
    input  logic            m1_cyc,
    input  logic            m1_stb,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_ack,
    output logic            m1_err,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_sel,
    output logic            s_we,
    output logic            s_cyc,
    output logic            s_stb,
    input  logic [DW-1:0]   s_rdata,
    input  logic            s_ack
);

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       wd_clr, wd_tick, wd_expire;

    // Datapath mux: the granted master sees the slave directly, everyone else sees zeros.
    always_comb begin
        s_addr   = '0;
        s_wdata  = '0;
        s_sel    = '0;
        s_we     = 1'b0;
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        m0_rdata = '0;
        m0_ack   = 1'b0;
        m1_rdata = '0;
        m1_ack   = 1'b0;
        unique case (state_q)
            ARB_G0: begin
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_sel    = m0_sel;
                s_we     = m0_we;
                s_cyc    = m0_cyc;
                s_stb    = m0_stb;
                m0_rdata = s_rdata;
                m0_ack   = s_ack;
            end
            ARB_G1: begin
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_sel    = m1_sel;
                s_we     = m1_we;
                s_cyc    = m1_cyc;
                s_stb    = m1_stb;
                m1_rdata = s_rdata;
                m1_ack   = s_ack;
            end
            default: ;
        endcase
    end

    assign m0_err = wd_expire && (state_q == ARB_G0);
    assign m1_err = wd_expire && (state_q == ARB_G1);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_d = last_grant_q ? ARB_G0 : ARB_G1;
                end else if (m0_cyc) begin
                    state_d = ARB_G0;
                end else if (m1_cyc) begin
                    state_d = ARB_G1;
                end
            end
            ARB_G0: begin
                if (wd_expire) begin
                    state_d      = ARB_ERR;
                    last_grant_d = 1'b0;
                end else if (!m0_cyc) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = 1'b0;
                end
            end
            ARB_G1: begin
                if (wd_expire) begin
                    state_d      = ARB_ERR;
                    last_grant_d = 1'b1;
                end else if (!m1_cyc) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Any state change counts as a grant change and restarts the wait count.
    assign wd_tick = s_cyc && s_stb && !s_ack;
    assign wd_clr  = !s_cyc || !s_stb || s_ack || (state_d != state_q);

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (wd_clr),
        .tick    (wd_tick),
        .expire  (wd_expire)
    );

endmodule
